// File: rtl/byte_transmitter_mux.sv
// TDO serializer with 2:1 output select for the JTAG TAP.
// Define BYTE_TX_MSB_FIRST_EN to transmit the word MSB first.
module byte_transmitter_mux #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] in,
  input  logic             tap_in,
  input  logic             select,
  output logic             tx_out,
  output logic             done
  ,output logic            tdo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sr;

  logic [CW-1:0]    cnt_d;
  logic [WIDTH-1:0] sr_d;
  logic             tx_d;
  logic             done_d;

  always_comb begin
    cnt_d  = cnt;
    sr_d   = sr;
    tx_d   = tx_out;
    done_d = done;
    if (enable) begin
      if (done) begin
        // counter frozen; line idles low until reset
        tx_d = 1'b0;
      end else if (cnt == '0) begin
`ifdef BYTE_TX_MSB_FIRST_EN
        tx_d = in[WIDTH-1];
        sr_d = in << 1;
`else
        tx_d = in[0];
        sr_d = in >> 1;
`endif
        cnt_d = ONE;
      end else begin
`ifdef BYTE_TX_MSB_FIRST_EN
        tx_d = sr[WIDTH-1];
        sr_d = sr << 1;
`else
        tx_d = sr[0];
        sr_d = sr >> 1;
`endif
        cnt_d  = cnt + ONE;
        done_d = (cnt == LAST);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      sr     <= '0;
      tx_out <= 1'b0;
      done   <= 1'b0;
    end else begin
      cnt    <= cnt_d;
      sr     <= sr_d;
      tx_out <= tx_d;
      done   <= done_d;
    end
  end

  assign tdo = select ? tap_in : tx_out;

endmodule

// File: tb/tb_byte_transmitter_mux.sv
// Directed bench for byte_transmitter_mux (WIDTH=32).
// Expected serial order follows BYTE_TX_MSB_FIRST_EN.
module tb_byte_transmitter_mux;

  localparam int W = 32;
  localparam logic [W-1:0] WA = 32'h000FAF01;
  localparam logic [W-1:0] WB = 32'hA5A5A5A5;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         enable = 1'b0;
  logic [W-1:0] in = '0;
  logic         tap_in = 1'b0;
  logic         select = 1'b0;
  logic         tx_out;
  logic         done;
  logic         tdo;

  int checks = 0;
  int passed = 0;

  byte_transmitter_mux #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .in(in),
    .tap_in(tap_in), .select(select), .tx_out(tx_out),
    .done(done), .tdo(tdo)
  );

  always #5 clk = ~clk;

  function automatic logic expb(input logic [W-1:0] w, input int k);
    logic [W-1:0] t;
    t = w;
`ifdef BYTE_TX_MSB_FIRST_EN
    return t[W-1-k];
`else
    return t[k];
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b1;
    in = WA;
    step();
    checks++;
    if (tx_out !== 1'b0) $display("FAIL reset_tx got %b want 0", tx_out);
    else passed++;
    checks++;
    if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done);
    else passed++;
    checks++;
    if (tdo !== 1'b0) $display("FAIL reset_tdo got %b want 0", tdo);
    else passed++;
    reset = 1'b0;
    enable = 1'b0;
  endtask

  task automatic test_full_word();
    logic b;
    do_reset();
    in = WA;
    select = 1'b0;
    enable = 1'b1;
    for (int k = 0; k < W; k++) begin
      step();
      b = expb(WA, k);
      checks++;
      if (tdo !== b) $display("FAIL full_tdo[%0d] got %b want %b", k, tdo, b);
      else passed++;
      checks++;
      if (done !== (k == W - 1))
        $display("FAIL full_done[%0d] got %b want %b", k, done, k == W - 1);
      else passed++;
    end
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (done !== 1'b1 || tx_out !== 1'b0)
        $display("FAIL after_done[%0d] got done=%b tx=%b want 1 0", k, done, tx_out);
      else passed++;
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (done !== 1'b0 || tx_out !== 1'b0)
      $display("FAIL rst_after_done got done=%b tx=%b want 0 0", done, tx_out);
    else passed++;
    in = WB;
    for (int k = 0; k < 8; k++) begin
      step();
      b = expb(WB, k);
      checks++;
      if (tx_out !== b) $display("FAIL a5_tx[%0d] got %b want %b", k, tx_out, b);
      else passed++;
    end
    enable = 1'b0;
  endtask

  task automatic test_pause();
    logic b;
    do_reset();
    in = WA;
    enable = 1'b1;
    for (int k = 0; k < W; k++) begin
      if (k == 5) begin
        enable = 1'b0;
        for (int p = 0; p < 3; p++) begin
          step();
          b = expb(WA, 4);
          checks++;
          if (tx_out !== b || done !== 1'b0)
            $display("FAIL pause_hold[%0d] got tx=%b done=%b want %b 0", p, tx_out, done, b);
          else passed++;
        end
        enable = 1'b1;
      end
      step();
      b = expb(WA, k);
      checks++;
      if (tx_out !== b || done !== (k == W - 1))
        $display("FAIL pause_tx[%0d] got tx=%b done=%b want %b %b", k, tx_out, done, b, k == W - 1);
      else passed++;
    end
    enable = 1'b0;
  endtask

  task automatic test_input_change();
    logic b;
    do_reset();
    in = WA;
    enable = 1'b1;
    for (int k = 0; k < W; k++) begin
      step();
      if (k == 0) in = 32'hFFFFFFFF;
      b = expb(WA, k);
      checks++;
      if (tx_out !== b) $display("FAIL inchg_tx[%0d] got %b want %b", k, tx_out, b);
      else passed++;
    end
    checks++;
    if (done !== 1'b1) $display("FAIL inchg_done got %b want 1", done);
    else passed++;
    enable = 1'b0;
  endtask

  task automatic test_reset_mid_word();
    logic b;
    do_reset();
    in = WA;
    enable = 1'b1;
    for (int k = 0; k < 9; k++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (tx_out !== 1'b0 || done !== 1'b0)
      $display("FAIL midrst got tx=%b done=%b want 0 0", tx_out, done);
    else passed++;
    in = WB;
    for (int k = 0; k < W; k++) begin
      step();
      b = expb(WB, k);
      checks++;
      if (tx_out !== b || done !== (k == W - 1))
        $display("FAIL midrst_tx[%0d] got tx=%b done=%b want %b %b", k, tx_out, done, b, k == W - 1);
      else passed++;
    end
    enable = 1'b0;
  endtask

  task automatic test_mux();
    logic b;
    do_reset();
    in = WB;
    enable = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      select = 1'b1;
      tap_in = 1'b0;
      #1;
      checks++;
      if (tdo !== 1'b0) $display("FAIL mux_tap0[%0d] got %b want 0", k, tdo);
      else passed++;
      tap_in = 1'b1;
      #1;
      checks++;
      if (tdo !== 1'b1) $display("FAIL mux_tap1[%0d] got %b want 1", k, tdo);
      else passed++;
      select = 1'b0;
      #1;
      b = expb(WB, k);
      checks++;
      if (tdo !== b) $display("FAIL mux_ser[%0d] got %b want %b", k, tdo, b);
      else passed++;
    end
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_pause();
    test_input_change();
    test_reset_mid_word();
    test_mux();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/byte_transmitter_mux.md
Name: byte_transmitter_mux

Overview:
- Parameterised serializer plus 2:1 output select, used by the JTAG TAP block to drive TDO.
- The serializer shifts a WIDTH-bit word, default 32 for the IDCODE DR register, onto a 1-bit line, LSB first, one bit per enabled clock. It flags completion when done.
- The output mux chooses between the TAP controller's own TDO bit and the serializer bit.

Parameters:
- WIDTH, 32: number of bits in the word to serialise; legal values are 2 or more.

Ports:
- clk  input  1  rising-edge clock (TCK domain).
- reset  input  1  synchronous, active-high reset; clears serializer state.
- enable  input  1  when high, one bit is shifted per rising edge.
- in  input  WIDTH  parallel word to transmit; captured at the first enabled edge of a transfer.
- tap_in  input  1  TDO bit from the TAP controller (mux input "one").
- select  input  1  1 selects tap_in, 0 selects the serializer bit.
- tx_out  output  1  registered serializer bit (mux input "two").
- done  output  1  high once the last bit has been driven.
- tdo  output  1  combinational mux output.

Behaviour:
- Single clock. Reset is synchronous and active-high and is sampled only on the rising edge of clk. Reset has priority over enable.
- Reset values: tx_out=0, done=0, bit counter=0, shift register=0.
- Internal state:
  - bit counter, width clog2(WIDTH)+1;
  - WIDTH-bit shift register.
- Edge with enable=1, done=0, counter=0:
  - load the shift register with in, shifted right by 1;
  - tx_out <= in[0];
  - counter <= 1.
- Edge with enable=1, done=0, 0<counter<WIDTH:
  - tx_out <= shift register bit 0;
  - shift register shifts right by 1, zero fill;
  - counter increments.
- Latency and completion:
  - bit k of in appears on tx_out after the (k+1)-th enabled edge;
  - done is registered and goes high on the same edge that drives bit WIDTH-1, i.e. the WIDTH-th enabled edge;
  - done and bit WIDTH-1 are therefore visible together.
- Edge with enable=1, done=1: tx_out <= 0. done stays 1 and the counter is frozen; there is no wrap-around and no auto-restart.
- Edge with enable=0: all state holds, so tx_out and done keep their values. Pausing mid-word resumes at the next bit.
- A changing in after the first enabled edge has no effect on the current transfer.
- Only reset restarts a transfer. Reset asserted mid-word aborts the transfer and returns all state to reset values on that edge.
- Simultaneous reset=1 and enable=1: reset wins.
- Mux is purely combinational: tdo = select ? tap_in : tx_out. It has no register and no reset dependency.

Optional Feature:
- Macro BYTE_TX_MSB_FIRST_EN.
- When defined: the serializer transmits MSB first, so the first enabled edge drives in[WIDTH-1] and the shift register shifts left. Timing and done behaviour are unchanged.
- When undefined (default): LSB-first transmission as described above.

Test Plan:
- Reset, then in=32'h000FAF01 with enable held high for 32 edges, select=0 -> tdo sequence 1,0,0,0,0,0,0,0, 1,1,1,1,0,1,0,1, 1,1,1,1,0,0,0,0, then 8 zeros. done=0 for edges 1-31 and done=1 from edge 32 with tx_out=0 (bit 31).
- Pause: enable high 5 edges, low 3 edges, high again -> tx_out and done hold during the pause, and the sequence continues with bit 5 with no bit lost or repeated.
- Input change: after edge 1, set in=32'hFFFFFFFF -> the remaining bits still follow 32'h000FAF01.
- After done, keep enable high 4 more edges -> done stays 1, tx_out=0. Then assert reset one edge -> done=0, tx_out=0, and a new transfer of 32'hA5A5A5A5 outputs 1,0,1,0,0,1,0,1...
- Reset mid-word at edge 10 together with enable=1 -> on that edge tx_out=0, done=0, counter=0. The next enabled edge outputs in[0].
- Mux: select=1, tap_in toggled 0/1 during a transfer -> tdo follows tap_in combinationally. select=0 -> tdo equals tx_out in the same cycle.
